led_strip_expander: RTL and testbench

- Downstream neighbour of the linear visualizer.
- Latches one frame of per-bin colours (rgb) and per-bin LED counts when the visualizer's data_v fires.
- Expands the frame into a serial stream of exactly LEDS pixels: bin 0's colour repeated LEDCounts[0] times, then bin 1's, and so on.
- Streams over a valid/ready handshake to the strip serializer.

---
 rtl/led_strip_expander.sv | 177 +++++++++++++++++
 tb/tb_led_strip_expander.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_strip_expander.sv
// led_strip_expander: latches one frame of per-bin colours/counts and expands
// it into exactly LEDS pixels over a valid/ready stream.
// Optional build macro LED_STRIP_ROTATE_EN: rotates each frame's pattern by an
// offset that advances by one pixel per completed frame.
module led_strip_expander #(
  parameter int LEDS    = 50,
  parameter int BIN_QTY = 12,
  parameter int CW      = $clog2(LEDS),
  parameter int DROPW   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BIN_QTY-1:0][23:0]      rgb_i,
  input  logic [BIN_QTY-1:0][CW-1:0]    LEDCounts_i,
  input  logic                          data_v_i,
  output logic [23:0]                   pixel_o,
  output logic                          pixel_v,
  input  logic                          pixel_ready,
  output logic                          pixel_last,
  output logic                          busy,
  output logic [DROPW-1:0]              frame_drops
);
  localparam int BW = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;

  typedef enum logic [1:0] {IDLE, SEEK, EMIT, PAD} state_t;

  state_t                     r_state, w_state_n;
  logic [BIN_QTY-1:0][23:0]   r_rgb;
  logic [BIN_QTY-1:0][CW-1:0] r_cnt;
  logic [BW-1:0]              r_b, w_b_n, w_b_inc;
  logic [CW-1:0]              r_rem, w_rem_n;
  logic [CW-1:0]              r_p, w_p_n;
  logic [CW-1:0]              w_cnt_inc;
  logic                       w_last_bin, w_silent, w_step, w_frame_end, w_pat_end;
  logic                       w_active;

`ifdef LED_STRIP_ROTATE_EN
  // r_q: pattern index, r_skip: silent pre-walk steps left, r_o: rotation offset
  logic [CW-1:0] r_q, w_q_n, r_skip, w_skip_n, r_o, w_o_n;
  assign w_silent  = (r_skip != '0);
  assign w_pat_end = w_step && (r_q == CW'(LEDS-1));
`else
  assign w_silent  = 1'b0;
  assign w_pat_end = 1'b0;
`endif

  assign w_active    = (r_state == EMIT) || (r_state == PAD);
  assign w_b_inc     = r_b + 1'b1;
  assign w_last_bin  = (r_b == BW'(BIN_QTY-1));
  assign w_cnt_inc   = w_last_bin ? '0 : r_cnt[w_b_inc];
  // Silent pre-walk steps advance without waiting for the consumer
  assign w_step      = w_active && (w_silent || pixel_ready);
  assign w_frame_end = w_step && !w_silent && (r_p == CW'(LEDS-1));

  assign pixel_v    = w_active && !w_silent;
  assign pixel_o    = (r_state == EMIT && !w_silent) ? r_rgb[r_b] : 24'h000000;
  assign pixel_last = pixel_v && (r_p == CW'(LEDS-1));
  assign busy       = (r_state != IDLE);

  // Next-state: frame start, zero-bin skipping, emission, padding, wrap
  always_comb begin
    w_state_n = r_state;
    w_b_n     = r_b;
    w_rem_n   = r_rem;
    w_p_n     = r_p;
`ifdef LED_STRIP_ROTATE_EN
    w_q_n     = r_q;
    w_skip_n  = r_skip;
    w_o_n     = r_o;
`endif
    case (r_state)
      IDLE: begin
        if (data_v_i) begin
          w_b_n     = '0;
          w_rem_n   = LEDCounts_i[0];
          w_p_n     = '0;
`ifdef LED_STRIP_ROTATE_EN
          w_q_n     = '0;
          w_skip_n  = r_o;
`endif
          w_state_n = (LEDCounts_i[0] == '0) ? SEEK : EMIT;
        end
      end
      SEEK: begin
        if (w_last_bin) begin
          w_state_n = PAD;
        end else begin
          w_b_n     = w_b_inc;
          w_rem_n   = w_cnt_inc;
          w_state_n = (w_cnt_inc == '0) ? SEEK : EMIT;
        end
      end
      default: begin
        if (w_step) begin
`ifdef LED_STRIP_ROTATE_EN
          w_q_n = r_q + 1'b1;
          if (w_silent) w_skip_n = r_skip - 1'b1;
          else          w_p_n    = r_p + 1'b1;
`else
          w_p_n = r_p + 1'b1;
`endif
          if (w_frame_end) begin
            w_state_n = IDLE;
`ifdef LED_STRIP_ROTATE_EN
            w_o_n = (r_o == CW'(LEDS-1)) ? '0 : r_o + 1'b1;
`endif
          end else if (w_pat_end) begin
            // Pattern exhausted before LEDS pixels: wrap to bin 0
            w_b_n     = '0;
            w_rem_n   = r_cnt[0];
`ifdef LED_STRIP_ROTATE_EN
            w_q_n     = '0;
`endif
            w_state_n = (r_cnt[0] == '0) ? SEEK : EMIT;
          end else if (r_state == EMIT) begin
            w_rem_n = r_rem - 1'b1;
            if (r_rem == CW'(1)) begin
              if (w_last_bin) begin
                w_state_n = PAD;
              end else begin
                w_b_n     = w_b_inc;
                w_rem_n   = w_cnt_inc;
                w_state_n = (w_cnt_inc == '0) ? SEEK : EMIT;
              end
            end
          end
        end
      end
    endcase
  end

  // State and walk registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_b     <= '0;
      r_rem   <= '0;
      r_p     <= '0;
`ifdef LED_STRIP_ROTATE_EN
      r_q     <= '0;
      r_skip  <= '0;
      r_o     <= '0;
`endif
    end else begin
      r_state <= w_state_n;
      r_b     <= w_b_n;
      r_rem   <= w_rem_n;
      r_p     <= w_p_n;
`ifdef LED_STRIP_ROTATE_EN
      r_q     <= w_q_n;
      r_skip  <= w_skip_n;
      r_o     <= w_o_n;
`endif
    end
  end

  // Frame capture: only accepted while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rgb <= '0;
      r_cnt <= '0;
    end else if (r_state == IDLE && data_v_i) begin
      r_rgb <= rgb_i;
      r_cnt <= LEDCounts_i;
    end
  end

  // Saturating count of frames offered while a frame is in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_drops <= '0;
    end else if (data_v_i && r_state != IDLE && frame_drops != {DROPW{1'b1}}) begin
      frame_drops <= frame_drops + 1'b1;
    end
  end

endmodule

// File: tb/tb_led_strip_expander.sv
// Directed bench for led_strip_expander (rotation checks when built with
// LED_STRIP_ROTATE_EN).
module tb_led_strip_expander;
  localparam int LEDS = 50;
  localparam int BQ   = 12;
  localparam int CW   = 6;
  localparam int DW   = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [BQ-1:0][23:0]    rgb_i = '0;
  logic [BQ-1:0][CW-1:0]  cnt_i = '0;
  logic                   data_v_i = 1'b0;
  logic                   pixel_ready = 1'b1;
  logic [23:0]            pixel_o;
  logic                   pixel_v, pixel_last, busy;
  logic [DW-1:0]          frame_drops;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [23:0] pix_q[$];
  logic [23:0] exp_q[$];
  bit          last_q[$];
  int          dv_cyc = -1, fv_cyc = -1, bubbles = 0, hold_err = 0;
  logic        prev_v = 1'b0, prev_rdy = 1'b0;
  logic [23:0] prev_pix = '0;
  bit          stall_en = 1'b0;
  int          ph = 0;
  int          cnt[BQ];
  logic [23:0] col[BQ];

  led_strip_expander #(.LEDS(LEDS), .BIN_QTY(BQ), .CW(CW), .DROPW(DW)) dut (
    .clk(clk), .rst(rst), .rgb_i(rgb_i), .LEDCounts_i(cnt_i), .data_v_i(data_v_i),
    .pixel_o(pixel_o), .pixel_v(pixel_v), .pixel_ready(pixel_ready),
    .pixel_last(pixel_last), .busy(busy), .frame_drops(frame_drops)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observe the stream away from the active edge
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (data_v_i && dv_cyc < 0) dv_cyc = cyc;
      if (pixel_v && fv_cyc < 0) fv_cyc = cyc;
      if (busy && !pixel_v) bubbles++;
      if (prev_v && !prev_rdy && (!pixel_v || pixel_o !== prev_pix)) hold_err++;
      if (pixel_v && pixel_ready) begin
        pix_q.push_back(pixel_o);
        last_q.push_back(pixel_last);
      end
    end
    prev_v   = pixel_v && rst;
    prev_rdy = pixel_ready;
    prev_pix = pixel_o;
  end

  // Backpressure pattern 1,0,0,1 repeating
  initial forever begin
    @(posedge clk);
    #1;
    if (stall_en) begin
      pixel_ready = (ph == 0 || ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  task automatic reset_dut();
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk); #1 rst = 1'b1;
  endtask

  task automatic set_frame();
    for (int i = 0; i < BQ; i++) begin
      cnt_i[i] = CW'(cnt[i]);
      rgb_i[i] = col[i];
    end
  endtask

  task automatic start_frame();
    pix_q.delete(); last_q.delete();
    dv_cyc = -1; fv_cyc = -1; bubbles = 0; hold_err = 0;
    @(posedge clk); #1 data_v_i = 1'b1;
    @(posedge clk); #1 data_v_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (k >= 2000) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic wait_pix(input string tag, input int n);
    int k;
    for (k = 0; k < 500; k++) begin
      if (pix_q.size() >= n) break;
      @(negedge clk);
    end
    if (k >= 500) chk({tag, "_pixwait"}, 1, 0);
  endtask

  // Reference: bins in order, truncated/padded to LEDS, then rotated
  task automatic build_exp(input int rot);
    logic [23:0] tmp[$];
    for (int b = 0; b < BQ; b++)
      for (int k = 0; k < cnt[b]; k++)
        if (tmp.size() < LEDS) tmp.push_back(col[b]);
    while (tmp.size() < LEDS) tmp.push_back(24'h000000);
    exp_q.delete();
    for (int i = 0; i < LEDS; i++) exp_q.push_back(tmp[(i + rot) % LEDS]);
  endtask

  task automatic check_frame(input string tag);
    int nbad = 0, nlast = 0;
    chk({tag, "_len"}, pix_q.size(), LEDS);
    for (int i = 0; i < pix_q.size() && i < LEDS; i++) begin
      if (pix_q[i] !== exp_q[i]) begin
        if (nbad == 0) $display("  %s first bad pixel %0d: got %h expected %h", tag, i, pix_q[i], exp_q[i]);
        nbad++;
      end
      if (last_q[i]) nlast++;
    end
    chk({tag, "_bad_pixels"}, nbad, 0);
    chk({tag, "_last_count"}, nlast, 1);
    if (last_q.size() >= LEDS) chk({tag, "_last_pos"}, last_q[LEDS-1], 1);
  endtask

  task automatic frame_a();
    for (int i = 0; i < BQ; i++) begin cnt[i] = 0; col[i] = 24'h111111 * (i + 1); end
    cnt[0] = 10; cnt[1] = 5;
    col[0] = 24'hFF0000; col[1] = 24'h00FF00;
    set_frame();
  endtask

  task automatic frame_b();
    for (int i = 0; i < BQ; i++) begin cnt[i] = 5; col[i] = {8'(i + 1), 8'hA5, 8'(i * 3)}; end
    set_frame();
  endtask

  initial begin
    // Reset values while held in reset
    #23;
    chk("rst_pixel_v", pixel_v, 0);
    chk("rst_pixel_o", pixel_o, 0);
    chk("rst_pixel_last", pixel_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drops", frame_drops, 0);
    @(negedge clk); #1 rst = 1'b1;

    // {10,5,0..}: 10 red, 5 green, 10 skip bubbles, 35 black
    reset_dut();
    frame_a();
    start_frame();
    wait_idle("t1");
    build_exp(0);
    check_frame("t1");
    chk("t1_latency", fv_cyc - dv_cyc, 1);
    chk("t1_bubbles", bubbles, 10);
    chk("t1_busy_end", busy, 0);

    // Counts sum to 60: truncated after bin 9
    reset_dut();
    frame_b();
    start_frame();
    wait_idle("t2");
    build_exp(0);
    check_frame("t2");
    chk("t2_latency", fv_cyc - dv_cyc, 1);
    chk("t2_pix49_bin9", (pix_q.size() >= LEDS) ? pix_q[LEDS-1] : 24'hx, col[9]);

    // Two leading zero bins then 50 of bin 2
    reset_dut();
    for (int i = 0; i < BQ; i++) begin cnt[i] = 0; col[i] = 24'h010203 * (i + 1); end
    cnt[2] = 50; col[2] = 24'h3377CC;
    set_frame();
    start_frame();
    wait_idle("t3");
    build_exp(0);
    check_frame("t3");
    chk("t3_latency", fv_cyc - dv_cyc, 3);

    // Backpressure: same stream as t1, outputs held through stalls
    reset_dut();
    frame_a();
    ph = 0; stall_en = 1'b1;
    start_frame();
    wait_idle("t4");
    stall_en = 1'b0;
    @(posedge clk); #1 pixel_ready = 1'b1;
    build_exp(0);
    check_frame("t4");
    chk("t4_hold", hold_err, 0);

    // Frame offered mid-stream is dropped
    reset_dut();
    frame_a();
    start_frame();
    wait_pix("t5", 20);
    @(posedge clk); #1 data_v_i = 1'b1;
    @(posedge clk); #1 data_v_i = 1'b0;
    wait_idle("t5");
    build_exp(0);
    check_frame("t5");
    chk("t5_drops1", frame_drops, 1);
    // Hold data_v high for hundreds of busy cycles: saturates
    @(posedge clk); #1 data_v_i = 1'b1;
    repeat (400) @(posedge clk);
    #1 data_v_i = 1'b0;
    wait_idle("t5s");
    chk("t5_drops_sat", frame_drops, 255);

    // Asynchronous reset mid-frame
    frame_a();
    start_frame();
    wait_pix("t6", 25);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_v", pixel_v, 0);
    chk("t6_async_drops", frame_drops, 0);
    chk("t6_async_busy", busy, 0);
    @(posedge clk); #1;
    chk("t6_hold_v", pixel_v, 0);
    @(negedge clk); #2 rst = 1'b1;
    frame_b();
    start_frame();
    wait_idle("t6");
    build_exp(0);
    check_frame("t6");
    chk("t6_latency", fv_cyc - dv_cyc, 1);

`ifdef LED_STRIP_ROTATE_EN
    // Rotation: offset advances one pixel per frame, wraps after LEDS frames
    reset_dut();
    for (int i = 0; i < BQ; i++) begin cnt[i] = 0; col[i] = 24'h000000; end
    cnt[0] = 10; cnt[1] = 40;
    col[0] = 24'hA0A0A0; col[1] = 24'h0B0B0B;
    set_frame();
    for (int f = 1; f <= 51; f++) begin
      start_frame();
      wait_idle("t7");
      if (f == 1)  begin build_exp(0); check_frame("t7_f1");  end
      if (f == 2)  begin build_exp(1); check_frame("t7_f2");  end
      if (f == 51) begin build_exp(0); check_frame("t7_f51"); end
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
